// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
// Pops words from the read port of a FIFO_8Words instance and sends each word
// as a stream of bytes on a valid/ready interface. The FIFO head word is
// combinational, so a word is captured in the same cycle it is popped. When the
// next word is already waiting, it is reloaded on the last-byte transfer, so
// there is no idle cycle between words.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   fifoEmpty      FIFO empty flag
//   fifoReadData   FIFO head word, valid whenever fifoEmpty=0
//   fifoReadEnable pop strobe to the FIFO (combinational, gated by reset)
//   byteData       current output byte (registered)
//   byteValid      byteData valid (registered)
//   byteReady      downstream accepts byteData when byteValid && byteReady
//   busy           a word is in progress
//   wordsSent      count of fully transmitted words, wraps at 16 bits
//   byteParity     XOR of byteData (only when SERIALIZER_PARITY_EN is defined)
//
// Build option: define SERIALIZER_PARITY_EN to add the byteParity output.

module fifo_word_serializer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifoEmpty,
    input  logic [WORD_WIDTH-1:0] fifoReadData,
    output logic                  fifoReadEnable,
    output logic [BYTE_WIDTH-1:0] byteData,
    output logic                  byteValid,
    input  logic                  byteReady,
    output logic                  busy,
    output logic [15:0]           wordsSent
`ifdef SERIALIZER_PARITY_EN
    ,
    output logic                  byteParity
`endif
);

    localparam int unsigned NUM_BYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Byte idx of a word in transmit order; shifts avoid variable part-selects.
    function automatic logic [BYTE_WIDTH-1:0] select_byte(
        input logic [WORD_WIDTH-1:0] word,
        input logic [CNT_W-1:0]      idx
    );
        logic [WORD_WIDTH-1:0] shifted;
        if (MSB_FIRST) begin
            shifted = word << (32'(idx) * BYTE_WIDTH);
            return shifted[WORD_WIDTH-1 -: BYTE_WIDTH];
        end else begin
            shifted = word >> (32'(idx) * BYTE_WIDTH);
            return shifted[BYTE_WIDTH-1:0];
        end
    endfunction

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [BYTE_WIDTH-1:0]   data_q,  data_d;
    logic                    valid_q, valid_d;
    logic [15:0]             sent_q,  sent_d;
    logic                    pop_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sent_q  <= sent_d;
        end
    end

    // Next-state, pop decision and next byte selection
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q;
        sent_d  = sent_q;
        pop_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop_c   = 1'b1;
                    shift_d = fifoReadData;
                    count_d = '0;
                    data_d  = select_byte(fifoReadData, '0);
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // byteValid is always high here, so byteReady alone marks a transfer
                if (byteReady) begin
                    if (count_q != LAST_IDX) begin
                        count_d = count_q + CNT_W'(1);
                        data_d  = select_byte(shift_q, count_q + CNT_W'(1));
                    end else begin
                        sent_d = sent_q + 16'd1;
                        if (!fifoEmpty) begin
                            // Reload in the same cycle so words run back to back
                            pop_c   = 1'b1;
                            shift_d = fifoReadData;
                            count_d = '0;
                            data_d  = select_byte(fifoReadData, '0);
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign fifoReadEnable = pop_c && !reset;
    assign byteData       = data_q;
    assign byteValid      = valid_q;
    assign busy           = (state_q == SEND);
    assign wordsSent      = sent_q;

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    // Parity follows data_d, so it is held with byteData during stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign byteParity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
module tb_fifo_word_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifoEmpty;
    logic [31:0] fifoReadData;
    logic        fifoReadEnable;
    logic [7:0]  byteData;
    logic        byteValid;
    logic        byteReady;
    logic        busy;
    logic [15:0] wordsSent;
`ifdef SERIALIZER_PARITY_EN
    logic        byteParity;
`endif

    // Second instance, LSB-first, driven directly by test_lsb_first
    logic        lsb_empty;
    logic [31:0] lsb_data;
    logic        lsb_rden;
    logic [7:0]  lsb_byte;
    logic        lsb_valid;
    logic        lsb_ready;
    logic        lsb_busy;
    logic [15:0] lsb_sent;
`ifdef SERIALIZER_PARITY_EN
    logic        lsb_parity;
`endif

    int compared = 0;
    int errors   = 0;

    // FIFO model: combinational head word, popped on fifoReadEnable
    logic [31:0] mem [0:63];
    int          head = 0;
    int          tail = 0;
    int          pops = 0;

    logic [7:0]  exp_q[$];
    logic        par_q[$];
    logic [7:0]  lsb_exp[$];
    logic [7:0]  mon_e;
    logic        mon_p;

    assign fifoEmpty    = (head == tail);
    assign fifoReadData = mem[head[5:0]];

    always #5 clk = ~clk;

    fifo_word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .fifoEmpty(fifoEmpty), .fifoReadData(fifoReadData),
        .fifoReadEnable(fifoReadEnable), .byteData(byteData), .byteValid(byteValid),
        .byteReady(byteReady), .busy(busy), .wordsSent(wordsSent)
`ifdef SERIALIZER_PARITY_EN
        , .byteParity(byteParity)
`endif
    );

    fifo_word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .fifoEmpty(lsb_empty), .fifoReadData(lsb_data),
        .fifoReadEnable(lsb_rden), .byteData(lsb_byte), .byteValid(lsb_valid),
        .byteReady(lsb_ready), .busy(lsb_busy), .wordsSent(lsb_sent)
`ifdef SERIALIZER_PARITY_EN
        , .byteParity(lsb_parity)
`endif
    );

    always @(posedge clk) begin
        if (fifoReadEnable === 1'b1) begin
            head <= head + 1;
            pops <= pops + 1;
        end
    end

    // Scoreboard: every accepted byte is checked against the expected stream
    always @(negedge clk) begin
        if (fifoEmpty) begin
            compared++;
            if (fifoReadEnable !== 1'b0) begin
                errors++;
                $display("FAIL pop_on_empty: fifoReadEnable=%b required 0 at %0t", fifoReadEnable, $time);
            end
        end
        if (byteValid === 1'b1 && byteReady === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: byteData=%h with empty scoreboard at %0t", byteData, $time);
            end else begin
                mon_e = exp_q.pop_front();
                mon_p = par_q.pop_front();
                if (byteData !== mon_e) begin
                    errors++;
                    $display("FAIL byte_stream: byteData=%h required %h at %0t", byteData, mon_e, $time);
                end
`ifdef SERIALIZER_PARITY_EN
                compared++;
                if (byteParity !== mon_p) begin
                    errors++;
                    $display("FAIL byte_parity: byteParity=%b required %b at %0t", byteParity, mon_p, $time);
                end
`endif
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        logic [7:0] b;
        mem[tail[5:0]] = w;
        tail = tail + 1;
        for (int k = 0; k < 4; k++) begin
            b = w[31-8*k -: 8];
            exp_q.push_back(b);
            par_q.push_back(^b);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        compared++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes pending busy=%b after %0d cycles", exp_q.size(), busy, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        byteReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if (byteValid !== 1'b0 || wordsSent !== 16'd0 || busy !== 1'b0 || byteData !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle: valid=%b sent=%h busy=%b data=%h required 0,0000,0,00",
                         byteValid, wordsSent, busy, byteData);
            end
        end
    endtask

    task automatic test_single_word();
        int p0 = pops;
        logic [15:0] s0 = wordsSent;
        @(posedge clk); #1;
        push_word(32'hA1B2C3D4);
        @(negedge clk);
        compared++;
        if (fifoReadEnable !== 1'b1) begin
            errors++;
            $display("FAIL pop_latency: fifoReadEnable=%b required 1", fifoReadEnable);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compared++;
            if (byteValid !== 1'b1) begin
                errors++;
                $display("FAIL single_valid: byte %0d byteValid=%b required 1", k, byteValid);
            end
        end
        @(negedge clk);
        compared++;
        if (byteValid !== 1'b0 || wordsSent !== 16'(s0 + 1) || pops != p0 + 1) begin
            errors++;
            $display("FAIL single_end: valid=%b sent=%h pops=%0d required 0,%h,%0d",
                     byteValid, wordsSent, pops - p0, 16'(s0 + 1), 1);
        end
    endtask

    task automatic test_back_to_back();
        int p0 = pops;
        logic [15:0] s0 = wordsSent;
        @(posedge clk); #1;
        push_word(32'h11223344);
        push_word(32'h55667788);
        @(negedge clk);
        compared++;
        if (fifoReadEnable !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_pop: fifoReadEnable=%b required 1", fifoReadEnable);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            compared++;
            if (byteValid !== 1'b1 || fifoReadEnable !== (k == 3)) begin
                errors++;
                $display("FAIL b2b_stream: cycle %0d valid=%b rden=%b required 1,%b",
                         k, byteValid, fifoReadEnable, (k == 3));
            end
        end
        @(negedge clk);
        compared++;
        if (byteValid !== 1'b0 || wordsSent !== 16'(s0 + 2) || pops != p0 + 2) begin
            errors++;
            $display("FAIL b2b_end: valid=%b sent=%h pops=%0d required 0,%h,2",
                     byteValid, wordsSent, pops - p0, 16'(s0 + 2));
        end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        push_word(32'hDEADBEEF);
        @(posedge clk); #1;
        byteReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (byteData !== 8'hDE || byteValid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d data=%h valid=%b busy=%b required de,1,1",
                         i, byteData, byteValid, busy);
            end
        end
        @(posedge clk); #1;
        byteReady = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] s0 = wordsSent;
        @(posedge clk); #1;
        push_word(32'hCAFEF00D);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        compared++;
        if (byteValid !== 1'b0 || busy !== 1'b0 || byteData !== 8'h00 || wordsSent !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b data=%h sent=%h required 0,0,00,0000 (before %h)",
                     byteValid, busy, byteData, wordsSent, s0);
        end
        compared++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL reset_mid_count: %0d bytes left required 2", exp_q.size());
        end
        exp_q.delete();
        par_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (byteValid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: byteValid=%b data=%h required 0", byteValid, byteData);
            end
        end
    endtask

`ifdef SERIALIZER_PARITY_EN
    task automatic test_parity();
        @(posedge clk); #1;
        push_word(32'h0103FF00);
        wait_drain(20);
    endtask
`endif

    task automatic test_lsb_first();
        lsb_exp.push_back(8'hD4);
        lsb_exp.push_back(8'hC3);
        lsb_exp.push_back(8'hB2);
        lsb_exp.push_back(8'hA1);
        @(posedge clk); #1;
        lsb_data  = 32'hA1B2C3D4;
        lsb_empty = 1'b0;
        @(negedge clk);
        compared++;
        if (lsb_rden !== 1'b1) begin
            errors++;
            $display("FAIL lsb_pop: fifoReadEnable=%b required 1", lsb_rden);
        end
        @(posedge clk); #1;
        lsb_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mon_e = lsb_exp.pop_front();
            compared++;
            if (lsb_valid !== 1'b1 || lsb_byte !== mon_e) begin
                errors++;
                $display("FAIL lsb_order: byte %0d valid=%b data=%h required 1,%h", k, lsb_valid, lsb_byte, mon_e);
            end
        end
        @(negedge clk);
        compared++;
        if (lsb_valid !== 1'b0 || lsb_sent !== 16'd1) begin
            errors++;
            $display("FAIL lsb_end: valid=%b sent=%h required 0,0001", lsb_valid, lsb_sent);
        end
    endtask

    initial begin
        reset     = 1'b1;
        byteReady = 1'b1;
        lsb_empty = 1'b1;
        lsb_data  = 32'h0;
        lsb_ready = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
`ifdef SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_reset_mid_word();
        test_lsb_first();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
